ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 8-bit ula datapath (add/sub/shift-left/NOR), selected by f1/f2.
- Accepts an operation from one requester, drives the ula inputs from registers and waits a programmable settle time. It then captures the ula result and returns it to the winner with an id tag.
- Sits between the register-file/control logic and the ula instance; nothing else drives the ula.

Parameters:
WIDTH, 8, operand/result width; must match the ula width
LAT, 1, ula settle cycles in EXEC before capture; legal range >= 1
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  2  requester 0 op {f1,f2}: 00 add, 01 sub, 10 shl, 11 nor
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
ula_a  output  WIDTH  registered operand a to ula
ula_b  output  WIDTH  registered operand b to ula
ula_f1  output  1  registered op bit 1 to ula
ula_f2  output  1  registered op bit 0 to ula
ula_r  input  WIDTH  ula result
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_data  output  WIDTH  captured ula result
resp_id  output  1  requester that issued the result
busy  output  1  high in EXEC or RESP
ops_done  output  CNTW  count of completed responses

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, priority pointer=0.
  - All outputs 0: ula_a/ula_b/ula_f1/ula_f2, resp_valid/resp_data/resp_id, busy, ops_done.
  - Reset mid-operation drops the in-flight op silently; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if only one reqN_valid is high, grant N. If both are high, grant the pointer value.
  - reqN_ready is combinational and asserted only for the granted requester, only in IDLE.
  - Accept at the edge where valid&ready: latch a/b into ula_a/ula_b, op into {ula_f1,ula_f2}, grant into resp_id; load the settle counter with LAT-1; go to EXEC.
  - No valid: stay in IDLE, all ready low.
- EXEC:
  - Ula inputs are held stable.
  - Counter decrements each cycle. At the edge where the counter is 0, capture ula_r into resp_data and go to RESP.
  - EXEC lasts exactly LAT cycles.
- RESP:
  - resp_valid=1; resp_data and resp_id held stable until resp_ready.
  - At the edge where resp_valid&resp_ready: go to IDLE, pointer <= ~resp_id, ops_done <= ops_done+1 (wraps max->0).
  - No requester ready is asserted in RESP.
- Latency:
  - Accept at edge k means resp_valid is high from cycle k+LAT+1.
  - Minimum spacing between accepts is LAT+2 cycles (with resp_ready held high).
- Ula inputs keep their last values in IDLE and RESP; they update only on accept.
- A requester may drop valid before it is granted without penalty. Operands are sampled only at the accept edge.
- busy = (state != IDLE).
- Fairness: under continuous requests from both, grants alternate 0,1,0,1...

Test Plan:
- Single add: req0 a=5 b=3 op=00, resp_ready=1 -> req0_ready high 1 cycle; resp_valid 2 cycles after accept, resp_data=8, resp_id=0, ops_done=1.
- Sub and shift: req1 a=5 b=3 op=01 -> resp_data=2, resp_id=1. Then req1 a=1 b=3 op=10 -> resp_data=8. ula_f1/ula_f2 must match op throughout EXEC.
- Contention: both valid continuously with distinct operands -> first grant 0, then 1, 0, 1; each response's id matches its operands; no grant while busy.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_data and resp_id held; req0_ready/req1_ready stay low; single completion when resp_ready rises.
- Reset mid-op: assert rst_n low during EXEC -> immediately resp_valid=0, busy=0, ula_* =0, ops_done=0. After release, a new req0 op completes normally with pointer=0.
- Counter wrap: with CNTW=4, complete 17 ops -> ops_done sequence reaches 15 then wraps to 0, final value 1. LAT=3 run: resp_valid 4 cycles after accept.

Source files
------------

// File: rtl/ula_arbiter.sv
// ula_arbiter: two-requester round-robin arbiter and sequencer for a shared
// 8-bit ula (add/sub/shl/nor). It accepts one operation, drives the ula
// inputs from registers, waits LAT settle cycles, captures the result and
// returns it to the winning requester with an id tag.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid/ready/a/b/op      requester N (N=0,1); ready is combinational
//   ula_a/ula_b/ula_f1/ula_f2    registered drive to the ula
//   ula_r                        ula result
//   resp_valid/ready/data/id     response channel
//   busy                         high while in EXEC or RESP
//   ops_done                     completed-response counter (wraps)
module ula_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic             ula_f1,
    output logic             ula_f2,
    input  logic [WIDTH-1:0] ula_r,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    // Settle counter only needs to hold LAT-1.
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic          ptr;
    logic [CW-1:0] cnt;

    logic grant_c;
    logic accept_c;

    // Pointer breaks ties; a lone requester always wins.
    always_comb begin
        grant_c  = (req0_valid && req1_valid) ? ptr : req1_valid;
        accept_c = (state == IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = accept_c && !grant_c;
    assign req1_ready = accept_c && grant_c;

    // Sequencer: accept -> settle -> respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_f1     <= 1'b0;
            ula_f2     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            busy       <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        ula_a   <= grant_c ? req1_a : req0_a;
                        ula_b   <= grant_c ? req1_b : req0_b;
                        ula_f1  <= grant_c ? req1_op[1] : req0_op[1];
                        ula_f2  <= grant_c ? req1_op[0] : req0_op[0];
                        resp_id <= grant_c;
                        cnt     <= CW'(LAT - 1);
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        resp_data  <= ula_r;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        ptr        <= ~resp_id;
                        ops_done   <= ops_done + CNTW'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: a LAT=1/CNTW=16 instance for the main
// behaviour and a LAT=3/CNTW=4 instance for latency and counter wrap.
module tb_ula_arbiter;

    logic clk;
    logic rst_n;

    // Instance 0 (LAT=1, CNTW=16)
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic [7:0]  ula_a, ula_b, ula_r, resp_data;
    logic        ula_f1, ula_f2, resp_valid, resp_ready, resp_id, busy;
    logic [15:0] ops_done;

    // Instance 1 (LAT=3, CNTW=4)
    logic        w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
    logic [7:0]  w_req0_a, w_req0_b, w_req1_a, w_req1_b;
    logic [1:0]  w_req0_op, w_req1_op;
    logic [7:0]  w_ula_a, w_ula_b, w_ula_r, w_resp_data;
    logic        w_ula_f1, w_ula_f2, w_resp_valid, w_resp_ready, w_resp_id, w_busy;
    logic [3:0]  w_ops_done;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    // Behavioural ula feeding the arbiter.
    function automatic logic [7:0] ula_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic f1, input logic f2);
        case ({f1, f2})
            2'b00:   return 8'(a + b);
            2'b01:   return 8'(a - b);
            2'b10:   return 8'(a << b);
            default: return ~(a | b);
        endcase
    endfunction

    assign ula_r   = ula_f(ula_a, ula_b, ula_f1, ula_f2);
    assign w_ula_r = ula_f(w_ula_a, w_ula_b, w_ula_f1, w_ula_f2);

    ula_arbiter #(.WIDTH(8), .LAT(1), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .ula_a(ula_a), .ula_b(ula_b), .ula_f1(ula_f1), .ula_f2(ula_f2),
        .ula_r(ula_r),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .busy(busy), .ops_done(ops_done)
    );

    ula_arbiter #(.WIDTH(8), .LAT(3), .CNTW(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready),
        .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_op(w_req0_op),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready),
        .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_op(w_req1_op),
        .ula_a(w_ula_a), .ula_b(w_ula_b), .ula_f1(w_ula_f1), .ula_f2(w_ula_f2),
        .ula_r(w_ula_r),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
        .resp_data(w_resp_data), .resp_id(w_resp_id),
        .busy(w_busy), .ops_done(w_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on instance 0; 'other' also raises the losing requester.
    task automatic do_op(input bit port, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp_data, input bit other);
        int n;
        @(negedge clk);
        if (!port) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
            if (other) begin
                req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 2'b11;
            end
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
            if (other) begin
                req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_op = 2'b11;
            end
        end
        resp_ready = 1'b1;
        #1;
        n = 0;
        while (!(port ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_ready", 32'(port ? req1_ready : req0_ready), 32'd1);
        chk("loser_ready", 32'(port ? req0_ready : req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("busy_exec", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(req0_ready | req1_ready), 32'd0);
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!resp_valid) begin
                chk("exec_f1", 32'(ula_f1), 32'(op[1]));
                chk("exec_f2", 32'(ula_f2), 32'(op[0]));
            end
        end while (!resp_valid && n < 20);
        chk("latency", 32'(n), 32'd2);
        chk("resp_data", 32'(resp_data), 32'(exp_data));
        chk("resp_id", 32'(resp_id), 32'(port));
        @(posedge clk); #1;
        exp_done++;
        chk("ops_done", 32'(ops_done), 32'(exp_done));
        chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    endtask

    // One add on instance 1 (LAT=3); expected counter value passed in.
    task automatic w_op(input logic [7:0] a, input logic [7:0] exp_data, input logic [3:0] exp_cnt);
        int n;
        @(negedge clk);
        w_req0_valid = 1'b1; w_req0_a = a; w_req0_b = 8'd1; w_req0_op = 2'b00;
        w_resp_ready = 1'b1;
        #1;
        chk("w_ready", 32'(w_req0_ready), 32'd1);
        @(posedge clk); #1;
        w_req0_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!w_resp_valid && n < 20);
        chk("w_latency", 32'(n), 32'd4);
        chk("w_resp_data", 32'(w_resp_data), 32'(exp_data));
        chk("w_resp_id", 32'(w_resp_id), 32'd0);
        @(posedge clk); #1;
        chk("w_ops_done", 32'(w_ops_done), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0; resp_ready = 0;
        w_req0_valid = 0; w_req1_valid = 0; w_req0_a = 0; w_req0_b = 0; w_req0_op = 0;
        w_req1_a = 0; w_req1_b = 0; w_req1_op = 0; w_resp_ready = 0;
        #2 rst_n = 1'b0;
        #20;
        // Reset state
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ula", 32'({ula_a, ula_b, ula_f1, ula_f2}), 32'd0);
        chk("rst_resp", 32'({resp_data, resp_id}), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        chk("rst_w_ops_done", 32'(w_ops_done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_no_ready", 32'(req0_ready | req1_ready), 32'd0);

        // Single add, then sub and shift from requester 1
        do_op(1'b0, 8'd5, 8'd3, 2'b00, 8'd8, 1'b0);
        do_op(1'b1, 8'd5, 8'd3, 2'b01, 8'd2, 1'b0);
        do_op(1'b1, 8'd1, 8'd3, 2'b10, 8'd8, 1'b0);
        chk("ula_hold_idle", 32'({ula_a, ula_b}), 32'h0103);

        // Contention: alternating grants with matching payloads
        @(negedge clk);
        req0_valid = 1; req0_a = 8'd10; req0_b = 8'd4; req0_op = 2'b00;
        req1_valid = 1; req1_a = 8'd9;  req1_b = 8'd2; req1_op = 2'b01;
        resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk); n++;
                if (busy && !resp_valid)
                    chk("busy_no_ready", 32'(req0_ready | req1_ready), 32'd0);
            end while (!resp_valid && n < 20);
            chk("cont_id", 32'(resp_id), 32'(i % 2));
            chk("cont_data", 32'(resp_data), (i % 2 == 0) ? 32'd14 : 32'd7);
            @(posedge clk);
        end
        #1;
        req0_valid = 0; req1_valid = 0;
        exp_done += 4;
        chk("cont_ops_done", 32'(ops_done), 32'(exp_done));

        // Backpressure: nor held across 5 stalled cycles
        @(negedge clk);
        req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h0C; req0_op = 2'b11;
        resp_ready = 0;
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_a = 8'd1; req1_b = 8'd1; req1_op = 2'b00;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", 32'(resp_data), 32'h03);
            chk("bp_id", 32'(resp_id), 32'd0);
            chk("bp_ready", 32'(req0_ready | req1_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1; req1_valid = 0;
        @(posedge clk); #1;
        exp_done++;
        chk("bp_release", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_single", 32'(ops_done), 32'(exp_done));

        // Reset during EXEC
        @(negedge clk);
        req1_valid = 1; req1_a = 8'd7; req1_b = 8'd7; req1_op = 2'b00;
        @(posedge clk); #1;
        req1_valid = 0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ula", 32'({ula_a, ula_b, ula_f1, ula_f2}), 32'd0);
        chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        exp_done = 0;
        // Both valid after reset: pointer=0 grants requester 0
        do_op(1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b1);

        // LAT=3, CNTW=4: 17 ops, counter wraps to 1
        for (int i = 0; i < 17; i++)
            w_op(8'(i), 8'(i + 1), 4'((i + 1) % 16));
        chk("w_final_cnt", 32'(w_ops_done), 32'd1);
        chk("w_idle", 32'({w_busy, w_req1_ready}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
